// File: rtl/ef_pin_in_demux.sv
// ef_pin_in_demux: synchronizes pad inputs and routes each pin to one of four peripheral slots,
// with a per-pin settle window on select changes. Define EF_PIN_IN_GLITCH_FILTER_EN for the glitch filter.
module ef_pin_in_demux #(
  parameter int   COUNT         = 32,
  parameter int   SYNC_STAGES   = 2,
  parameter int   SETTLE_CYCLES = 4,
  parameter logic IDLE_LEVEL    = 1'b1,
  parameter int   FILTER_LEN    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [COUNT-1:0]     io_in,
  input  logic [COUNT-1:0]     sel0,
  input  logic [COUNT-1:0]     sel1,
  output logic [COUNT*4-1:0]   p_in,
  output logic [COUNT-1:0]     sel_busy,
  output logic [COUNT-1:0]     rise,
  output logic [COUNT-1:0]     fall
);

  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);
`ifdef EF_PIN_IN_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FC_LAST = FW'(FILTER_LEN - 1);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < COUNT; gi++) begin : g_pin
      logic [SYNC_STAGES-1:0] r_sync;
      logic [1:0]             r_sel_q;
      logic [CW-1:0]          r_cnt;
      logic [3:0]             r_slot;
      logic                   r_lvl;
      logic                   r_rise;
      logic                   r_fall;
      logic                   w_q;
      logic [1:0]             w_sel;

      assign w_sel = {sel1[gi], sel0[gi]};

      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], io_in[gi]};
        end
      end

`ifdef EF_PIN_IN_GLITCH_FILTER_EN
      logic [FW-1:0] r_fc;
      logic          r_q;

      // q only follows the synchronized input after FILTER_LEN consecutive disagreeing cycles
      always_ff @(posedge clk) begin
        if (rst) begin
          r_q  <= IDLE_LEVEL;
          r_fc <= '0;
        end else if (r_sync[SYNC_STAGES-1] == r_q) begin
          r_fc <= '0;
        end else if (r_fc == FC_LAST) begin
          r_q  <= r_sync[SYNC_STAGES-1];
          r_fc <= '0;
        end else begin
          r_fc <= r_fc + FW'(1);
        end
      end

      assign w_q = r_q;
`else
      assign w_q = r_sync[SYNC_STAGES-1];
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          r_sel_q <= 2'b00;
          r_cnt   <= '0;
          r_slot  <= {4{IDLE_LEVEL}};
          r_lvl   <= IDLE_LEVEL;
          r_rise  <= 1'b0;
          r_fall  <= 1'b0;
        end else begin
          // any select change (re)starts the settle window
          if (w_sel != r_sel_q) begin
            r_sel_q <= w_sel;
            r_cnt   <= SETTLE_LOAD;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end
          for (int k = 0; k < 4; k++) begin
            r_slot[k] <= (r_cnt == '0 && r_sel_q == 2'(k)) ? w_q : IDLE_LEVEL;
          end
          r_lvl  <= w_q;
          r_rise <= w_q & ~r_lvl;
          r_fall <= ~w_q & r_lvl;
        end
      end

      assign p_in[gi*4 +: 4] = r_slot;
      assign sel_busy[gi]    = (r_cnt != '0);
      assign rise[gi]        = r_rise;
      assign fall[gi]        = r_fall;
    end
  endgenerate

endmodule

// File: tb/tb_ef_pin_in_demux.sv
// Scoreboard bench for ef_pin_in_demux (COUNT=4): expectations are queued with a target edge
// when stimulus is driven and compared when that edge arrives.
module tb_ef_pin_in_demux;

  localparam int N  = 4;
  localparam int ST = 4;
`ifdef EF_PIN_IN_GLITCH_FILTER_EN
  localparam int FL = 3;
  localparam int PW = 2;
`else
  localparam int FL = 0;
  localparam int PW = 1;
`endif
  localparam int LAT = 2 + 1 + FL;

  localparam int K_P = 0;
  localparam int K_B = 1;
  localparam int K_R = 2;
  localparam int K_F = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   io_in = '0;
  logic [N-1:0]   sel0 = '0;
  logic [N-1:0]   sel1 = '0;
  logic [4*N-1:0] p_in;
  logic [N-1:0]   sel_busy;
  logic [N-1:0]   rise;
  logic [N-1:0]   fall;

  ef_pin_in_demux #(
    .COUNT(N), .SYNC_STAGES(2), .SETTLE_CYCLES(ST), .IDLE_LEVEL(1'b1), .FILTER_LEN(3)
  ) dut (
    .clk(clk), .rst(rst), .io_in(io_in), .sel0(sel0), .sel1(sel1),
    .p_in(p_in), .sel_busy(sel_busy), .rise(rise), .fall(fall)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    at;
    int    kind;
    int    idx;
    logic  val;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic expect_at(int at, int kind, int idx, logic val, string nm);
    exp_t e;
    e.at = at; e.kind = kind; e.idx = idx; e.val = val; e.nm = nm;
    sb.push_back(e);
  endtask

  function automatic logic actual(int kind, int idx);
    case (kind)
      K_P:     return p_in[idx];
      K_B:     return sel_busy[idx];
      K_R:     return rise[idx];
      default: return fall[idx];
    endcase
  endfunction

  task automatic test_reset();
    int c0;
    rst = 1'b1; io_in = '0; sel0 = '0; sel1 = '0;
    tick(); tick();
    n_checks++;
    if (p_in !== 16'hFFFF) begin n_fail++; $display("FAIL reset_p_in: got %h, expected ffff", p_in); end
    n_checks++;
    if (sel_busy !== 4'h0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0000", sel_busy); end
    n_checks++;
    if (rise !== 4'h0) begin n_fail++; $display("FAIL reset_rise: got %b, expected 0000", rise); end
    n_checks++;
    if (fall !== 4'h0) begin n_fail++; $display("FAIL reset_fall: got %b, expected 0000", fall); end
    rst = 1'b0;
    c0 = cyc;
    for (int i = 0; i < N; i++) begin
      expect_at(c0 + 1, K_B, i, 1'b0, "rel_busy");
      expect_at(c0 + LAT - 1, K_P, 4*i, 1'b1, "rel_slot0_pre");
      expect_at(c0 + LAT, K_P, 4*i, 1'b0, "rel_slot0");
      expect_at(c0 + LAT, K_P, 4*i + 1, 1'b1, "rel_slot1_idle");
      expect_at(c0 + LAT, K_F, i, 1'b1, "rel_fall");
      expect_at(c0 + LAT + 1, K_F, i, 1'b0, "rel_fall_end");
    end
    for (int t = 0; t < LAT + 2; t++) begin
      tick();
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].at == cyc) begin
          n_checks++;
          if (actual(sb[j].kind, sb[j].idx) !== sb[j].val) begin
            n_fail++;
            $display("FAIL %s[%0d] @edge %0d: got %b, expected %b", sb[j].nm, sb[j].idx, cyc,
                     actual(sb[j].kind, sb[j].idx), sb[j].val);
          end
          sb.delete(j);
        end
      end
    end
  endtask

  task automatic test_route();
    int c0, e, b1, b2, t1, t2;
    c0 = cyc; e = c0 + 1; t1 = 7; t2 = t1 + LAT + 2;
    b1 = c0 + t1; b2 = c0 + t2;
    expect_at(e, K_B, 2, 1'b1, "route_busy_start");
    expect_at(e + 3, K_B, 2, 1'b1, "route_busy_last");
    expect_at(e + 4, K_B, 2, 1'b0, "route_busy_end");
    expect_at(e, K_P, 8, 1'b0, "route_old_slot");
    expect_at(e + 1, K_P, 8, 1'b1, "route_settle_idle");
    expect_at(e + 4, K_P, 10, 1'b1, "route_settle_idle2");
    expect_at(e + 5, K_P, 10, 1'b0, "route_new_slot");
    expect_at(b1 + LAT - 1, K_P, 10, 1'b0, "route_rise_pre");
    expect_at(b1 + LAT, K_P, 10, 1'b1, "route_rise_p");
    expect_at(b1 + LAT, K_R, 2, 1'b1, "route_rise");
    expect_at(b1 + LAT + 1, K_R, 2, 1'b0, "route_rise_end");
    expect_at(b2 + LAT - 1, K_P, 10, 1'b1, "route_fall_pre");
    expect_at(b2 + LAT, K_P, 10, 1'b0, "route_fall_p");
    expect_at(b2 + LAT, K_F, 2, 1'b1, "route_fall");
    expect_at(b2 + LAT + 1, K_F, 2, 1'b0, "route_fall_end");
    expect_at(b2 + LAT, K_P, 8, 1'b1, "route_other_slot");
    expect_at(b2 + LAT, K_P, 9, 1'b1, "route_other_slot");
    expect_at(b2 + LAT, K_P, 11, 1'b1, "route_other_slot");
    for (int t = 0; t < t2 + LAT + 2; t++) begin
      if (t == 0) sel1[2] = 1'b1;
      if (t == t1) io_in[2] = 1'b1;
      if (t == t2) io_in[2] = 1'b0;
      tick();
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].at == cyc) begin
          n_checks++;
          if (actual(sb[j].kind, sb[j].idx) !== sb[j].val) begin
            n_fail++;
            $display("FAIL %s[%0d] @edge %0d: got %b, expected %b", sb[j].nm, sb[j].idx, cyc,
                     actual(sb[j].kind, sb[j].idx), sb[j].val);
          end
          sb.delete(j);
        end
      end
    end
  endtask

  task automatic test_settle();
    int e;
    e = cyc + 1;
    for (int d = 0; d < ST; d++) expect_at(e + d, K_B, 0, 1'b1, "settle_busy");
    expect_at(e + ST, K_B, 0, 1'b0, "settle_busy_end");
    expect_at(e, K_P, 0, 1'b0, "settle_old_slot");
    for (int d = 1; d <= ST; d++)
      for (int k = 0; k < 4; k++) expect_at(e + d, K_P, k, 1'b1, "settle_idle");
    expect_at(e + ST + 1, K_P, 3, 1'b0, "settle_new_slot");
    expect_at(e + ST + 1, K_P, 0, 1'b1, "settle_old_released");
    for (int t = 0; t < ST + 3; t++) begin
      if (t == 0) begin sel0[0] = 1'b1; sel1[0] = 1'b1; end
      tick();
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].at == cyc) begin
          n_checks++;
          if (actual(sb[j].kind, sb[j].idx) !== sb[j].val) begin
            n_fail++;
            $display("FAIL %s[%0d] @edge %0d: got %b, expected %b", sb[j].nm, sb[j].idx, cyc,
                     actual(sb[j].kind, sb[j].idx), sb[j].val);
          end
          sb.delete(j);
        end
      end
    end
  endtask

  task automatic test_restart();
    int e;
    e = cyc + 1;
    for (int d = 0; d < ST + 2; d++) expect_at(e + d, K_B, 0, 1'b1, "restart_busy");
    expect_at(e + ST + 2, K_B, 0, 1'b0, "restart_busy_end");
    expect_at(e, K_P, 3, 1'b0, "restart_old_slot");
    for (int d = 1; d <= ST + 2; d++)
      for (int k = 0; k < 4; k++) expect_at(e + d, K_P, k, 1'b1, "restart_idle");
    expect_at(e + ST + 3, K_P, 2, 1'b0, "restart_final_slot");
    expect_at(e + ST + 3, K_P, 1, 1'b1, "restart_stale_slot");
    for (int t = 0; t < ST + 5; t++) begin
      if (t == 0) sel1[0] = 1'b0;
      if (t == 2) begin sel0[0] = 1'b0; sel1[0] = 1'b1; end
      tick();
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].at == cyc) begin
          n_checks++;
          if (actual(sb[j].kind, sb[j].idx) !== sb[j].val) begin
            n_fail++;
            $display("FAIL %s[%0d] @edge %0d: got %b, expected %b", sb[j].nm, sb[j].idx, cyc,
                     actual(sb[j].kind, sb[j].idx), sb[j].val);
          end
          sb.delete(j);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int c0, t1, t2, b1, b2;
    c0 = cyc; t1 = LAT + 3; t2 = t1 + PW + LAT + 4;
    b1 = c0 + t1; b2 = c0 + t2;
    expect_at(c0 + LAT, K_P, 4, 1'b1, "glitch_high");
    expect_at(c0 + LAT, K_R, 1, 1'b1, "glitch_setup_rise");
`ifdef EF_PIN_IN_GLITCH_FILTER_EN
    for (int d = 1; d <= LAT + 3; d++) begin
      expect_at(b1 + d, K_P, 4, 1'b1, "glitch_filtered_p");
      expect_at(b1 + d, K_F, 1, 1'b0, "glitch_filtered_fall");
    end
`else
    expect_at(b1 + LAT - 1, K_P, 4, 1'b1, "glitch_pre");
    expect_at(b1 + LAT, K_P, 4, 1'b0, "glitch_pulse_p");
    expect_at(b1 + LAT, K_F, 1, 1'b1, "glitch_pulse_fall");
    expect_at(b1 + LAT + 1, K_P, 4, 1'b1, "glitch_pulse_end");
    expect_at(b1 + LAT + 1, K_R, 1, 1'b1, "glitch_pulse_rise");
`endif
    expect_at(b2 + LAT - 1, K_P, 4, 1'b1, "glitch_step_pre");
    expect_at(b2 + LAT, K_P, 4, 1'b0, "glitch_step_p");
    expect_at(b2 + LAT, K_F, 1, 1'b1, "glitch_step_fall");
    expect_at(b2 + LAT + 1, K_F, 1, 1'b0, "glitch_step_fall_end");
    for (int t = 0; t < t2 + LAT + 2; t++) begin
      if (t == 0) io_in[1] = 1'b1;
      if (t == t1) io_in[1] = 1'b0;
      if (t == t1 + PW) io_in[1] = 1'b1;
      if (t == t2) io_in[1] = 1'b0;
      tick();
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].at == cyc) begin
          n_checks++;
          if (actual(sb[j].kind, sb[j].idx) !== sb[j].val) begin
            n_fail++;
            $display("FAIL %s[%0d] @edge %0d: got %b, expected %b", sb[j].nm, sb[j].idx, cyc,
                     actual(sb[j].kind, sb[j].idx), sb[j].val);
          end
          sb.delete(j);
        end
      end
    end
  endtask

  task automatic test_reset_mid_settle();
    int c0, r;
    c0 = cyc; r = c0 + 3;
    expect_at(c0 + 2, K_B, 3, 1'b1, "rmid_busy_before");
    expect_at(r, K_B, 3, 1'b0, "rmid_busy_reset");
    for (int k = 0; k < 4*N; k++) expect_at(r, K_P, k, 1'b1, "rmid_p_idle");
    for (int i = 0; i < N; i++) begin
      expect_at(r, K_R, i, 1'b0, "rmid_rise");
      expect_at(r, K_F, i, 1'b0, "rmid_fall");
    end
    for (int d = 1; d <= ST; d++) expect_at(r + d, K_B, 3, 1'b1, "rmid_new_busy");
    expect_at(r + ST + 1, K_B, 3, 1'b0, "rmid_new_busy_end");
    expect_at(r + ST + 1, K_P, 13, 1'b1, "rmid_slot_idle");
    expect_at(r + ST + 2, K_P, 13, 1'b0, "rmid_slot_routed");
    for (int t = 0; t < ST + 6; t++) begin
      if (t == 0) sel1[3] = 1'b1;
      if (t == 2) begin rst = 1'b1; sel1[3] = 1'b0; sel0[3] = 1'b1; end
      if (t == 3) rst = 1'b0;
      tick();
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].at == cyc) begin
          n_checks++;
          if (actual(sb[j].kind, sb[j].idx) !== sb[j].val) begin
            n_fail++;
            $display("FAIL %s[%0d] @edge %0d: got %b, expected %b", sb[j].nm, sb[j].idx, cyc,
                     actual(sb[j].kind, sb[j].idx), sb[j].val);
          end
          sb.delete(j);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_route();
    test_settle();
    test_restart();
    test_glitch();
    test_reset_mid_settle();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
